// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//   Conditions four raw, bouncing push-buttons (Start, Red, Green, Blue) into
//   clean single-cycle press pulses for a downstream code detector. Each
//   channel is independent and identical:
//     - a 2-flop synchronizer for the asynchronous raw level
//     - a debounce FSM {UP, PRESS_WAIT, DOWN, REL_WAIT} with a CNT_W-bit
//       counter. A press or release is accepted only after DB_CYCLES
//       consecutive stable synchronized cycles.
//   Only an accepted press (PRESS_WAIT -> DOWN) emits a pulse. Releases never
//   pulse. Multi flags any cycle in which two or more press pulses coincide.
//
// Parameters
//   DB_CYCLES  stable cycles needed to accept an edge (2 .. 2**CNT_W-1)
//   CNT_W      width of each debounce counter
//
// Ports
//   Clk                                 single clock, rising edge
//   Rst                                 async active-low reset. Deassertion
//                                       must already be synchronous to Clk.
//   BtnStart, BtnRed, BtnGreen, BtnBlue raw button levels, 1 = pressed
//   Start, Red, Green, Blue             registered one-cycle press pulses
//   Multi                               registered, coincident with >=2 pulses
// -----------------------------------------------------------------------------
module button_conditioner #(
  parameter int DB_CYCLES = 8,
  parameter int CNT_W     = 4
) (
  input  logic Clk,
  input  logic Rst,
  input  logic BtnStart,
  input  logic BtnRed,
  input  logic BtnGreen,
  input  logic BtnBlue,
  output logic Start,
  output logic Red,
  output logic Green,
  output logic Blue,
  output logic Multi
);

  localparam logic [1:0] ST_UP         = 2'd0;
  localparam logic [1:0] ST_PRESS_WAIT = 2'd1;
  localparam logic [1:0] ST_DOWN       = 2'd2;
  localparam logic [1:0] ST_REL_WAIT   = 2'd3;

  localparam logic [CNT_W-1:0] LP_CNT_MAX = CNT_W'(DB_CYCLES - 1);

  // Channel order: bit 0 Start, 1 Red, 2 Green, 3 Blue.
  logic [3:0] w_raw;
  logic [3:0] w_pulse_next;
  logic [3:0] r_pulse;
  logic       w_multi_next;
  logic       r_multi;

  assign w_raw = {BtnBlue, BtnGreen, BtnRed, BtnStart};

  for (genvar g = 0; g < 4; g++) begin : g_ch
    logic             r_sync1;
    logic             r_sync2;
    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_at_max;

    assign w_at_max = (r_cnt == LP_CNT_MAX);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values; blocking here would collapse the synchronizer.
    always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
        r_sync1 <= 1'b0;
        r_sync2 <= 1'b0;
        r_state <= ST_UP;
        r_cnt   <= '0;
      end else begin
        r_sync1 <= w_raw[g];
        r_sync2 <= r_sync1;
        r_state <= w_state_next;
        r_cnt   <= w_cnt_next;
      end
    end

    // NOTE: defaults at the top of the block guarantee every path assigns
    // both outputs, so no latch is inferred.
    always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      case (r_state)
        ST_UP: begin
          if (r_sync2) begin
            w_state_next = ST_PRESS_WAIT;
            w_cnt_next   = CNT_W'(1);
          end else begin
            w_cnt_next   = '0;
          end
        end
        ST_PRESS_WAIT: begin
          if (!r_sync2) begin
            w_state_next = ST_UP;
            w_cnt_next   = '0;
          end else if (w_at_max) begin
            w_state_next = ST_DOWN;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next   = r_cnt + CNT_W'(1);
          end
        end
        ST_DOWN: begin
          if (!r_sync2) begin
            w_state_next = ST_REL_WAIT;
            w_cnt_next   = CNT_W'(1);
          end else begin
            w_cnt_next   = '0;
          end
        end
        ST_REL_WAIT: begin
          if (r_sync2) begin
            w_state_next = ST_DOWN;
            w_cnt_next   = '0;
          end else if (w_at_max) begin
            w_state_next = ST_UP;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next   = r_cnt + CNT_W'(1);
          end
        end
        default: begin
          w_state_next = ST_UP;
          w_cnt_next   = '0;
        end
      endcase
    end

    // The pulse is armed on the same edge that commits PRESS_WAIT -> DOWN.
    assign w_pulse_next[g] = (r_state == ST_PRESS_WAIT) && r_sync2 && w_at_max;
  end

  // Two or more of four: any pair set.
  assign w_multi_next = (w_pulse_next[0] & w_pulse_next[1]) |
                        (w_pulse_next[0] & w_pulse_next[2]) |
                        (w_pulse_next[0] & w_pulse_next[3]) |
                        (w_pulse_next[1] & w_pulse_next[2]) |
                        (w_pulse_next[1] & w_pulse_next[3]) |
                        (w_pulse_next[2] & w_pulse_next[3]);

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_pulse <= '0;
      r_multi <= 1'b0;
    end else begin
      r_pulse <= w_pulse_next;
      r_multi <= w_multi_next;
    end
  end

  assign Start = r_pulse[0];
  assign Red   = r_pulse[1];
  assign Green = r_pulse[2];
  assign Blue  = r_pulse[3];
  assign Multi = r_multi;

endmodule

// File: tb/tb_button_conditioner.sv
// -----------------------------------------------------------------------------
// tb_button_conditioner
//   Directed bench for button_conditioner with DB_CYCLES = 8. Button and
//   output vectors use bit order {Blue, Green, Red, Start}. The expected word
//   is {Multi, Blue, Green, Red, Start}. A press first sampled at edge 0
//   pulses in the cycle observed just after edge 9.
// -----------------------------------------------------------------------------
module tb_button_conditioner;

  localparam logic [3:0] M_START = 4'b0001;
  localparam logic [3:0] M_RED   = 4'b0010;
  localparam logic [3:0] M_GREEN = 4'b0100;
  localparam logic [3:0] M_BLUE  = 4'b1000;
  localparam int         N_VEC   = 160;

  logic Clk;
  logic Rst;
  logic [3:0] btn;
  logic Start, Red, Green, Blue, Multi;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [3:0] btn;
    logic [4:0] exp;
  } vec_t;

  vec_t vec [N_VEC];

  button_conditioner #(.DB_CYCLES(8), .CNT_W(4)) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .BtnStart (btn[0]),
    .BtnRed   (btn[1]),
    .BtnGreen (btn[2]),
    .BtnBlue  (btn[3]),
    .Start    (Start),
    .Red      (Red),
    .Green    (Green),
    .Blue     (Blue),
    .Multi    (Multi)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [4:0] outs();
    return {Multi, Blue, Green, Red, Start};
  endfunction

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Hold b for n edges. Expect exp_mask only at tick index pulse_at (-1: never).
  task automatic run_phase(input string name, input logic [3:0] b, input int n,
                           input int pulse_at, input logic [3:0] exp_mask);
    btn = b;
    for (int i = 0; i < n; i++) begin
      tick();
      check($sformatf("%s[%0d]", name, i), outs(),
            (i == pulse_at) ? {1'b0, exp_mask} : 5'b0);
    end
  endtask

  initial begin
    // ---------------- vector table ----------------
    for (int i = 0; i < N_VEC; i++) begin
      vec[i].btn = 4'b0;
      vec[i].exp = 5'b0;
      if (i < 40)                          vec[i].btn = M_RED;
      if (i >= 60 && i < 85)               vec[i].btn = M_RED | M_GREEN;
      if ((i >= 105 && i < 108) || (i >= 111 && i < 114) || (i >= 117 && i < 137))
        vec[i].btn = M_BLUE;
    end
    vec[9].exp   = {1'b0, M_RED};            // clean press
    vec[69].exp  = {1'b1, M_RED | M_GREEN};  // simultaneous, Multi set
    vec[126].exp = {1'b0, M_BLUE};           // 9 edges after stable hold at 117

    // ---------------- reset, Red held through it ----------------
    Rst = 1'b1;
    btn = M_RED;
    #2 Rst = 1'b0;
    #1 check("reset_async", outs(), 5'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("reset_hold[%0d]", i), outs(), 5'b0);
    end
    Rst = 1'b1;

    // ---------------- table: clean press, simultaneous, bounce ----------------
    for (int i = 0; i < N_VEC; i++) begin
      btn = vec[i].btn;
      tick();
      check($sformatf("vec[%0d]", i), outs(), vec[i].exp);
    end

    // ---------------- release bounce on Green ----------------
    run_phase("g_press",  M_GREEN, 20, 9, M_GREEN);
    run_phase("g_drop4",  4'b0,     4, -1, 4'b0);
    run_phase("g_rise2",  M_GREEN,  2, -1, 4'b0);
    run_phase("g_drop20", 4'b0,    20, -1, 4'b0);
    run_phase("g_again",  M_GREEN, 12, 9, M_GREEN);
    // A 7-cycle release is one short of accepted: no new pulse.
    run_phase("g_low7",   4'b0,     7, -1, 4'b0);
    run_phase("g_hi7",    M_GREEN, 15, -1, 4'b0);
    // An 8-cycle release is accepted: the next press pulses.
    run_phase("g_low8",   4'b0,     8, -1, 4'b0);
    run_phase("g_hi8",    M_GREEN, 15, 9, M_GREEN);
    run_phase("g_idle",   4'b0,    12, -1, 4'b0);

    // ---------------- reset mid-debounce on Start ----------------
    run_phase("s_pre",    M_START,  5, -1, 4'b0);
    #3 Rst = 1'b0;                     // asynchronous, mid-cycle
    #1 check("s_rst_now", outs(), 5'b0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check($sformatf("s_rst_hold[%0d]", i), outs(), 5'b0);
    end
    Rst = 1'b1;
    btn = M_START;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("s_post[%0d]", i), outs(),
            (i == 9) ? {1'b0, M_START} : 5'b0);
    end
    // Reset that lands while the pulse is high must clear it immediately.
    run_phase("s_rel",    4'b0,    12, -1, 4'b0);
    run_phase("s_p2",     M_START,  9, -1, 4'b0);
    tick();
    check("s_pulse_hi", outs(), {1'b0, M_START});
    #2 Rst = 1'b0;
    #1 check("s_pulse_cleared", outs(), 5'b0);
    tick();
    Rst = 1'b1;
    run_phase("s_p3",     M_START, 12, 9, M_START);
    run_phase("s_idle",   4'b0,    12, -1, 4'b0);

    // ---------------- code sequence to the detector ----------------
    run_phase("seq_start", M_START, 15, 9, M_START);
    run_phase("seq_gap0",  4'b0,    15, -1, 4'b0);
    run_phase("seq_red",   M_RED,   15, 9, M_RED);
    run_phase("seq_gap1",  4'b0,    15, -1, 4'b0);
    run_phase("seq_blue",  M_BLUE,  15, 9, M_BLUE);
    run_phase("seq_gap2",  4'b0,    15, -1, 4'b0);
    run_phase("seq_green", M_GREEN, 15, 9, M_GREEN);
    run_phase("seq_gap3",  4'b0,    15, -1, 4'b0);
    run_phase("seq_red2",  M_RED,   15, 9, M_RED);
    run_phase("seq_gap4",  4'b0,    15, -1, 4'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
